// File: rtl/real_accum_stage.sv
// real_accum_stage
//   Block accumulator placed after the fixed-point real multiplier stage.
//   It accepts one svreal-format product per valid/ready beat and aligns it
//   from IN_EXPONENT to OUT_EXPONENT. It sums exactly N_ACC beats, then holds
//   the block sum on out/out_valid until the consumer takes it.
//
//   Optional feature macro: SVREAL_ACC_SAT_EN
//     defined   : alignment and every add saturate; ovf is the sticky OR of
//                 saturation events in the block, presented with out.
//     undefined : adds wrap modulo 2**OUT_WIDTH; ovf stays 0.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   clr       in   synchronous abort (drops partial sum and pending result)
//   in        in   product mantissa, IN_WIDTH bits, value = in * 2**IN_EXPONENT
//   in_valid  in   in carries a sample
//   in_ready  out  stage accepts a sample this cycle
//   out       out  block sum mantissa, OUT_WIDTH bits, exponent OUT_EXPONENT
//   out_valid out  out holds a completed block sum
//   out_ready in   consumer takes out this cycle
//   ovf       out  block saturated (saturating build only)
module real_accum_stage #(
  parameter int IN_WIDTH     = 16,
  parameter int IN_EXPONENT  = -8,
  parameter int OUT_WIDTH    = 24,
  parameter int OUT_EXPONENT = -8,
  parameter int N_ACC        = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic [IN_WIDTH-1:0]  in,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OUT_WIDTH-1:0] out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 ovf
);

  localparam int SHIFT_D   = IN_EXPONENT - OUT_EXPONENT;
  localparam int SHIFT_ABS = (SHIFT_D >= 0) ? SHIFT_D : -SHIFT_D;
  // Wide enough that neither the left shift nor the sign extension loses bits.
  localparam int EXT_W     = IN_WIDTH + OUT_WIDTH + SHIFT_ABS;
  localparam int CNT_W     = $clog2(N_ACC + 1);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(N_ACC - 1);
  localparam logic [OUT_WIDTH-1:0] MAX_V    = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] MIN_V    = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  // Align one sample to the output exponent. Returns {saturation_event, value}.
  function automatic logic [OUT_WIDTH:0] align_fn(input logic [IN_WIDTH-1:0] x);
    logic signed [EXT_W-1:0] wide;
`ifdef SVREAL_ACC_SAT_EN
    logic [EXT_W-OUT_WIDTH:0] upper;
`endif
    wide = {{(EXT_W-IN_WIDTH){x[IN_WIDTH-1]}}, x};
    // Right shift is arithmetic, so negative values truncate toward -inf.
    if (SHIFT_D >= 0) begin
      wide = wide <<< SHIFT_ABS;
    end else begin
      wide = wide >>> SHIFT_ABS;
    end
`ifdef SVREAL_ACC_SAT_EN
    // Fits in OUT_WIDTH only if every bit from the output sign bit up matches.
    upper = wide[EXT_W-1:OUT_WIDTH-1];
    if ((&upper) || (~|upper)) begin
      align_fn = {1'b0, wide[OUT_WIDTH-1:0]};
    end else if (wide[EXT_W-1]) begin
      align_fn = {1'b1, MIN_V};
    end else begin
      align_fn = {1'b1, MAX_V};
    end
`else
    align_fn = {1'b0, wide[OUT_WIDTH-1:0]};
`endif
  endfunction

  // OUT_WIDTH+1 bit add. Returns {saturation_event, value}.
  function automatic logic [OUT_WIDTH:0] add_fn(input logic [OUT_WIDTH-1:0] a,
                                                input logic [OUT_WIDTH-1:0] b);
    logic [OUT_WIDTH:0] sum;
    sum = {a[OUT_WIDTH-1], a} + {b[OUT_WIDTH-1], b};
`ifdef SVREAL_ACC_SAT_EN
    // Top two bits disagree on overflow; the extra bit carries the true sign.
    if (sum[OUT_WIDTH] != sum[OUT_WIDTH-1]) begin
      add_fn = {1'b1, (sum[OUT_WIDTH] ? MIN_V : MAX_V)};
    end else begin
      add_fn = {1'b0, sum[OUT_WIDTH-1:0]};
    end
`else
    add_fn = {1'b0, sum[OUT_WIDTH-1:0]};
`endif
  endfunction

  state_t               state_q, state_d;
  logic [OUT_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0] out_q, out_d;
  logic                 ovf_q, ovf_d;
  logic                 ovf_acc_q, ovf_acc_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;

  logic [OUT_WIDTH:0]   aligned_s;
  logic [OUT_WIDTH:0]   sum_s;
  logic                 evt_s;
  logic                 beat_s;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign ovf       = ovf_q;

  // Next-state and datapath for the ACCUM/HOLD controller.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    ovf_d       = ovf_q;
    ovf_acc_d   = ovf_acc_q;
    aligned_s   = align_fn(in);
    sum_s       = add_fn(acc_q, aligned_s[OUT_WIDTH-1:0]);
    evt_s       = aligned_s[OUT_WIDTH] | sum_s[OUT_WIDTH];
    beat_s      = in_valid && in_ready_q;

    if (clr) begin
      // out keeps its last value on abort; everything else restarts.
      state_d   = ACCUM;
      acc_d     = '0;
      cnt_d     = '0;
      ovf_d     = 1'b0;
      ovf_acc_d = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (beat_s) begin
            if (cnt_q == CNT_LAST) begin
              out_d     = sum_s[OUT_WIDTH-1:0];
              ovf_d     = ovf_acc_q | evt_s;
              acc_d     = '0;
              cnt_d     = '0;
              ovf_acc_d = 1'b0;
              state_d   = HOLD;
            end else begin
              acc_d     = sum_s[OUT_WIDTH-1:0];
              cnt_d     = cnt_q + CNT_W'(1);
              ovf_acc_d = ovf_acc_q | evt_s;
            end
          end else begin
            state_d = ACCUM;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d = ACCUM;
          end else begin
            state_d = HOLD;
          end
        end
        default: begin
          state_d = ACCUM;
        end
      endcase
    end

    // Handshake flags are registered images of the next state.
    in_ready_d  = (state_d == ACCUM);
    out_valid_d = (state_d == HOLD);
  end

  // State and datapath registers. in_ready stays low during reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      ovf_q       <= 1'b0;
      ovf_acc_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      ovf_q       <= ovf_d;
      ovf_acc_q   <= ovf_acc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_real_accum_stage.sv
module tb_real_accum_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;

  // dut0 default parameters, dut1 OUT_EXPONENT=-4,
  // dut2 OUT_WIDTH=16/N_ACC=2, dut3 N_ACC=1
  logic [15:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
  logic iv0 = 1'b0, iv1 = 1'b0, iv2 = 1'b0, iv3 = 1'b0;
  logic or0 = 1'b1, or1 = 1'b1, or2 = 1'b1, or3 = 1'b1;
  logic ir0, ir1, ir2, ir3;
  logic ov0, ov1, ov2, ov3;
  logic ovf0, ovf1, ovf2, ovf3;
  logic [23:0] out0, out1, out3;
  logic [15:0] out2;

  int total = 0;
  int bad = 0;
  int seen = 0;
  logic [24:0] exp_q[$];

  always #5 clk = ~clk;

  real_accum_stage u_dut0 (
    .clk(clk), .rst(rst), .clr(clr), .in(in0), .in_valid(iv0), .in_ready(ir0),
    .out(out0), .out_valid(ov0), .out_ready(or0), .ovf(ovf0));

  real_accum_stage #(.OUT_EXPONENT(-4)) u_dut1 (
    .clk(clk), .rst(rst), .clr(clr), .in(in1), .in_valid(iv1), .in_ready(ir1),
    .out(out1), .out_valid(ov1), .out_ready(or1), .ovf(ovf1));

  real_accum_stage #(.OUT_WIDTH(16), .N_ACC(2)) u_dut2 (
    .clk(clk), .rst(rst), .clr(clr), .in(in2), .in_valid(iv2), .in_ready(ir2),
    .out(out2), .out_valid(ov2), .out_ready(or2), .ovf(ovf2));

  real_accum_stage #(.N_ACC(1)) u_dut3 (
    .clk(clk), .rst(rst), .clr(clr), .in(in3), .in_valid(iv3), .in_ready(ir3),
    .out(out3), .out_valid(ov3), .out_ready(or3), .ovf(ovf3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy_of(input int sel);
    case (sel)
      0:       rdy_of = ir0;
      1:       rdy_of = ir1;
      2:       rdy_of = ir2;
      default: rdy_of = ir3;
    endcase
  endfunction

  // One accepted beat on the selected DUT (bounded wait for in_ready).
  task automatic beat(input int sel, input logic [15:0] v);
    int n;
    n = 0;
    case (sel)
      0:       begin in0 = v; iv0 = 1'b1; end
      1:       begin in1 = v; iv1 = 1'b1; end
      2:       begin in2 = v; iv2 = 1'b1; end
      default: begin in3 = v; iv3 = 1'b1; end
    endcase
    while (!rdy_of(sel) && n < 50) begin
      tick();
      n++;
    end
    chk($sformatf("beat_ready_dut%0d", sel), 32'(rdy_of(sel)), 32'(1));
    tick();
    iv0 = 1'b0; iv1 = 1'b0; iv2 = 1'b0; iv3 = 1'b0;
  endtask

  task automatic push0(input logic [23:0] v, input logic o);
    exp_q.push_back({o, v});
  endtask

  // Scoreboard pop for dut0: wait (bounded) for out_valid, then compare.
  task automatic sb_check0();
    int n;
    logic [24:0] e;
    n = 0;
    while (ov0 !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    chk("sb_out_valid_seen", 32'(ov0), 32'(1));
    chk("sb_queue_nonempty", 32'(exp_q.size() > 0), 32'(1));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_out", 32'(out0), 32'(e[23:0]));
      chk("sb_ovf", 32'(ovf0), 32'(e[24]));
      seen++;
    end
  endtask

  initial begin
    int beats;
    int cyc;
    logic [15:0] exp2;
    logic exp2_ovf;

    // Reset state while rst is asserted.
    #2;
    chk("rst_out", 32'(out0), 32'(0));
    chk("rst_out_valid", 32'(ov0), 32'(0));
    chk("rst_ovf", 32'(ovf0), 32'(0));
    chk("rst_in_ready", 32'(ir0), 32'(0));
    tick();
    tick();
    rst = 1'b0;
    chk("rel_in_ready_low", 32'(ir0), 32'(0));
    tick();
    chk("rel_in_ready_high", 32'(ir0), 32'(1));

    // 1: four beats of 1.0 -> 4.0, out_valid one cycle after last beat, one wide.
    for (int i = 0; i < 4; i++) beat(0, 16'd256);
    push0(24'd1024, 1'b0);
    chk("t1_valid_rise", 32'(ov0), 32'(1));
    chk("t1_in_ready_low", 32'(ir0), 32'(0));
    sb_check0();
    tick();
    chk("t1_valid_one_wide", 32'(ov0), 32'(0));
    chk("t1_in_ready_back", 32'(ir0), 32'(1));

    // 2: hold result with out_ready=0; extra in_valid ignored.
    or0 = 1'b0;
    for (int i = 0; i < 4; i++) beat(0, 16'd256);
    push0(24'd1024, 1'b0);
    sb_check0();
    in0 = 16'd999;
    iv0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_hold_valid", 32'(ov0), 32'(1));
      chk("t2_hold_ready", 32'(ir0), 32'(0));
      chk("t2_hold_out", 32'(out0), 32'(1024));
    end
    iv0 = 1'b0;
    or0 = 1'b1;
    tick();
    chk("t2_release", 32'(ov0), 32'(0));
    for (int i = 0; i < 4; i++) beat(0, 16'd10);
    push0(24'd40, 1'b0);
    sb_check0();
    tick();

    // 5a: clr after two beats discards the partial sum.
    beat(0, 16'd7);
    beat(0, 16'd7);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t5_clr_ready", 32'(ir0), 32'(1));
    for (int i = 0; i < 4; i++) beat(0, 16'd100);
    push0(24'd400, 1'b0);
    sb_check0();
    tick();

    // clr in HOLD drops out_valid but out keeps its value.
    or0 = 1'b0;
    for (int i = 0; i < 4; i++) beat(0, 16'd1);
    push0(24'd4, 1'b0);
    sb_check0();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_hold_valid", 32'(ov0), 32'(0));
    chk("clr_hold_out_kept", 32'(out0), 32'(4));
    chk("clr_hold_ready", 32'(ir0), 32'(1));

    // 5b: rst in HOLD clears out/out_valid asynchronously.
    for (int i = 0; i < 4; i++) beat(0, 16'd5);
    push0(24'd20, 1'b0);
    sb_check0();
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(ov0), 32'(0));
    chk("t5_rst_out", 32'(out0), 32'(0));
    chk("t5_rst_ready", 32'(ir0), 32'(0));
    tick();
    rst = 1'b0;
    or0 = 1'b1;
    tick();
    chk("t5_after_rst_ready", 32'(ir0), 32'(1));
    chk("t5_after_rst_valid", 32'(ov0), 32'(0));

    // 6: random in_valid with in=-1, three blocks, exact beat count.
    beats = 0;
    cyc = 0;
    seen = 0;
    in0 = 16'hFFFF;
    while (beats < 12 && cyc < 600) begin
      iv0 = 1'($urandom_range(0, 1));
      if (iv0 && ir0) begin
        beats++;
        if (beats % 4 == 0) push0(24'hFFFFFC, 1'b0);
      end
      tick();
      cyc++;
      if (ov0) sb_check0();
    end
    iv0 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t6_no_extra_valid", 32'(ov0), 32'(0));
    end
    chk("t6_blocks_seen", 32'(seen), 32'(3));
    chk("t6_queue_drained", 32'(exp_q.size()), 32'(0));

    // 3: OUT_EXPONENT=-4 alignment with floor truncation.
    beat(1, 16'd384);
    beat(1, 16'hFE7F);   // -385
    beat(1, 16'd0);
    beat(1, 16'd16);
    chk("t3_valid", 32'(ov1), 32'(1));
    chk("t3_out", 32'(out1), 32'(0));
    tick();
    for (int i = 0; i < 4; i++) beat(1, 16'hFFFF);
    chk("t3_floor_out", 32'(out1), 32'(24'hFFFFFC));

    // 4: OUT_WIDTH=16, N_ACC=2 overflow handling.
`ifdef SVREAL_ACC_SAT_EN
    exp2 = 16'h7FFF;
    exp2_ovf = 1'b1;
`else
    exp2 = 16'hFFFE;
    exp2_ovf = 1'b0;
`endif
    beat(2, 16'h7FFF);
    beat(2, 16'h7FFF);
    chk("t4_valid", 32'(ov2), 32'(1));
    chk("t4_out", 32'(out2), 32'(exp2));
    chk("t4_ovf", 32'(ovf2), 32'(exp2_ovf));
    tick();
    beat(2, 16'd1);
    beat(2, 16'd1);
    chk("t4_next_out", 32'(out2), 32'(2));
    chk("t4_next_ovf_clear", 32'(ovf2), 32'(0));

    // N_ACC=1: each beat becomes a result directly.
    beat(3, 16'hFFFB);   // -5
    chk("n1_valid", 32'(ov3), 32'(1));
    chk("n1_out", 32'(out3), 32'(24'hFFFFFB));
    tick();
    chk("n1_valid_drop", 32'(ov3), 32'(0));
    beat(3, 16'd3);
    chk("n1_out2", 32'(out3), 32'(3));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
